// File: rtl/branch_redirect_unit_pkg.sv
// Shared constants for the branch redirect unit: defaults, FSM encodings and
// BTB saturating-counter values.
package branch_redirect_unit_pkg;

  localparam int unsigned WORD_SIZE_DEF = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_ISSUE   = 2'd2;

  localparam logic [1:0] CTR_INIT  = 2'd1;
  localparam logic [1:0] CTR_ALLOC = 2'd2;
  localparam logic [1:0] CTR_MAX   = 2'd3;

  // 2-bit saturating counter step toward taken / not-taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'd0) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_redirect_unit_btb_table.sv
// Direct-mapped branch target buffer: combinational lookup port and a single
// write port that trains the 2-bit counter or allocates on a taken miss.
module btb_table
  import branch_redirect_unit_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned ENTRIES   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] i_rd_pc,
  output logic                 o_rd_taken,
  output logic [WORD_SIZE-1:0] o_rd_target,
  input  logic                 i_wr_en,
  input  logic [WORD_SIZE-1:0] i_wr_pc,
  input  logic                 i_wr_taken,
  input  logic [WORD_SIZE-1:0] i_wr_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = WORD_SIZE - IDX_W;

  logic                 r_valid  [ENTRIES];
  logic [TAG_W-1:0]     r_tag    [ENTRIES];
  logic [WORD_SIZE-1:0] r_target [ENTRIES];
  logic [1:0]           r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic             w_rd_hit;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  logic             w_wr_hit;

  assign w_rd_idx    = i_rd_pc[IDX_W-1:0];
  assign w_rd_tag    = i_rd_pc[WORD_SIZE-1:IDX_W];
  assign w_rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_taken  = w_rd_hit && r_ctr[w_rd_idx][1];
  assign o_rd_target = r_target[w_rd_idx];

  assign w_wr_idx = i_wr_pc[IDX_W-1:0];
  assign w_wr_tag = i_wr_pc[WORD_SIZE-1:IDX_W];
  assign w_wr_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);

  // Hit: train counter (and refresh target when taken). Taken miss: replace entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[IDX_W'(i)]  <= 1'b0;
        r_tag[IDX_W'(i)]    <= '0;
        r_target[IDX_W'(i)] <= '0;
        r_ctr[IDX_W'(i)]    <= CTR_INIT;
      end
    end else if (i_wr_en) begin
      if (w_wr_hit) begin
        r_ctr[w_wr_idx] <= ctr_next(r_ctr[w_wr_idx], i_wr_taken);
        if (i_wr_taken) r_target[w_wr_idx] <= i_wr_target;
      end else if (i_wr_taken) begin
        r_valid[w_wr_idx]  <= 1'b1;
        r_tag[w_wr_idx]    <= w_wr_tag;
        r_target[w_wr_idx] <= i_wr_target;
        r_ctr[w_wr_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Control-hazard unit: BTB next-PC prediction at fetch, mispredict detection at
// resolution, and a stall-aware redirect pulse with per-stage flush.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
  parameter int unsigned BTB_ENTRIES  = 16,
  parameter int unsigned FLUSH_STAGES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WORD_SIZE-1:0]    if_pc,
  output logic [WORD_SIZE-1:0]    pred_target,
  output logic                    pred_taken,
  input  logic                    res_valid,
  input  logic                    res_is_branch,
  input  logic [WORD_SIZE-1:0]    res_pc,
  input  logic [WORD_SIZE-1:0]    res_fetched_next,
  input  logic [WORD_SIZE-1:0]    res_actual_next,
  input  logic                    stall,
  output logic                    force_pc,
  output logic [WORD_SIZE-1:0]    force_pc_data,
  output logic [FLUSH_STAGES-1:0] flush,
  output logic [CNT_WIDTH-1:0]    mispredict_count
);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [WORD_SIZE-1:0] r_redirect;
  logic [CNT_WIDTH-1:0] r_count;

  logic                 w_accept;
  logic                 w_mispredict;
  logic                 w_issue;
  logic                 w_upd_en;
  logic                 w_upd_taken;
  logic [WORD_SIZE-1:0] w_btb_target;

  btb_table #(
    .WORD_SIZE (WORD_SIZE),
    .ENTRIES   (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .i_rd_pc     (if_pc),
    .o_rd_taken  (pred_taken),
    .o_rd_target (w_btb_target),
    .i_wr_en     (w_upd_en),
    .i_wr_pc     (res_pc),
    .i_wr_taken  (w_upd_taken),
    .i_wr_target (res_actual_next)
  );

  assign pred_target = pred_taken ? w_btb_target : (if_pc + WORD_SIZE'(1));

  // Resolution inputs are only trusted while no redirect is outstanding.
  assign w_accept     = res_valid && (r_state == ST_IDLE);
  assign w_mispredict = w_accept && (res_fetched_next != res_actual_next);
  assign w_upd_en     = w_accept && res_is_branch;
  assign w_upd_taken  = (res_actual_next != (res_pc + WORD_SIZE'(1)));
  assign w_issue      = (r_state == ST_PENDING) && !stall;

  assign force_pc         = w_issue;
  assign force_pc_data    = r_redirect;
  assign flush            = {FLUSH_STAGES{w_issue}};
  assign mispredict_count = r_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_mispredict) w_state_nxt = ST_PENDING;
      ST_PENDING: if (!stall) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_redirect <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_mispredict) r_redirect <= res_actual_next;
      if (w_issue && (r_count != {CNT_WIDTH{1'b1}})) r_count <= r_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Randomized + directed bench for branch_redirect_unit against a behavioural
// BTB / redirect model.
module tb_branch_redirect_unit;

  localparam int unsigned W  = 16;
  localparam int unsigned NE = 16;
  localparam int unsigned FS = 2;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  if_pc;
  logic [W-1:0]  pred_target;
  logic          pred_taken;
  logic          res_valid;
  logic          res_is_branch;
  logic [W-1:0]  res_pc;
  logic [W-1:0]  res_fetched_next;
  logic [W-1:0]  res_actual_next;
  logic          stall;
  logic          force_pc;
  logic [W-1:0]  force_pc_data;
  logic [FS-1:0] flush;
  logic [CW-1:0] mispredict_count;

  branch_redirect_unit #(
    .WORD_SIZE(W), .BTB_ENTRIES(NE), .FLUSH_STAGES(FS), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_target(pred_target),
    .pred_taken(pred_taken), .res_valid(res_valid), .res_is_branch(res_is_branch),
    .res_pc(res_pc), .res_fetched_next(res_fetched_next),
    .res_actual_next(res_actual_next), .stall(stall), .force_pc(force_pc),
    .force_pc_data(force_pc_data), .flush(flush), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_valid  [NE];
  int unsigned m_tag    [NE];
  int unsigned m_target [NE];
  int unsigned m_ctr    [NE];
  bit          m_pending;
  bit          m_cool;
  int unsigned m_redirect;
  int unsigned m_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned inc(input int unsigned pc);
    return (pc + 1) % 65536;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_pending = 0; m_cool = 0; m_redirect = 0; m_count = 0;
  endtask

  task automatic check_outputs();
    int unsigned idx, exp_tgt;
    bit hit, exp_pt, exp_force;
    idx       = if_pc % NE;
    hit       = m_valid[idx] && (m_tag[idx] == if_pc / NE);
    exp_pt    = hit && (m_ctr[idx] >= 2);
    exp_tgt   = exp_pt ? m_target[idx] : inc(if_pc);
    exp_force = m_pending && !stall;
    chk("pred_taken", 32'(pred_taken), 32'(exp_pt));
    chk("pred_target", 32'(pred_target), exp_tgt);
    chk("force_pc", 32'(force_pc), 32'(exp_force));
    chk("flush", 32'(flush), exp_force ? 32'h3 : 32'h0);
    chk("force_pc_data", 32'(force_pc_data), m_redirect);
    chk("mispredict_count", 32'(mispredict_count), m_count);
  endtask

  task automatic model_update();
    bit issue, acc, taken, hit;
    int unsigned idx;
    issue  = m_pending && !stall;
    acc    = res_valid && !m_pending && !m_cool;
    m_cool = issue;
    if (issue) begin
      m_pending = 0;
      if (m_count < 15) m_count++;
    end
    if (acc && (res_fetched_next != res_actual_next)) begin
      m_pending  = 1;
      m_redirect = res_actual_next;
    end
    if (acc && res_is_branch) begin
      idx   = res_pc % NE;
      hit   = m_valid[idx] && (m_tag[idx] == res_pc / NE);
      taken = (res_actual_next != inc(res_pc));
      if (taken && hit) begin
        m_target[idx] = res_actual_next;
        if (m_ctr[idx] < 3) m_ctr[idx]++;
      end else if (taken) begin
        m_valid[idx] = 1; m_tag[idx] = res_pc / NE;
        m_target[idx] = res_actual_next; m_ctr[idx] = 2;
      end else if (hit) begin
        if (m_ctr[idx] > 0) m_ctr[idx]--;
      end
    end
  endtask

  // Called just after a falling edge: check, clock once, advance model.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_res(input bit v, input bit br, input int unsigned pc,
                         input int unsigned fn, input int unsigned an);
    res_valid = v; res_is_branch = br; res_pc = W'(pc);
    res_fetched_next = W'(fn); res_actual_next = W'(an);
  endtask

  task automatic clr_res();
    set_res(0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear before any edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_force_pc", 32'(force_pc), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_count", 32'(mispredict_count), 32'h0);
    chk("rst_data", 32'(force_pc_data), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned pool [6];
    int unsigned tgts [4];
    int unsigned pc, an, fn;
    pool[0] = 'h10; pool[1] = 'h20; pool[2] = 'h30; pool[3] = 'h13;
    pool[4] = 'h23; pool[5] = 'hFFFF;
    tgts[0] = 'h40; tgts[1] = 'h0; tgts[2] = 'h1234; tgts[3] = 'h77;

    reset = 1'b1; stall = 1'b0; if_pc = '0; clr_res();
    model_reset();
    #12;
    @(negedge clk);
    reset = 1'b0;

    // Reset state and cold prediction
    if_pc = 16'h0010;
    #1 chk("cold_pred_target", 32'(pred_target), 32'h11);
    chk("cold_pred_taken", 32'(pred_taken), 32'h0);
    cycle();

    // First taken mispredict
    set_res(1, 1, 'h10, 'h11, 'h40);
    cycle();
    clr_res();
    #1 chk("redir_force", 32'(force_pc), 32'h1);
    chk("redir_data", 32'(force_pc_data), 32'h40);
    chk("redir_flush", 32'(flush), 32'h3);
    cycle();
    #1 chk("redir_once", 32'(force_pc), 32'h0);
    chk("redir_count", 32'(mispredict_count), 32'h1);
    chk("trained_taken", 32'(pred_taken), 32'h1);
    chk("trained_target", 32'(pred_target), 32'h40);
    cycle();

    // Stall holds the redirect; wrong-path resolution is ignored
    stall = 1'b1;
    set_res(1, 0, 'h30, 'h31, 'h55);
    cycle();
    set_res(1, 1, 'h50, 'h51, 'h99);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_hold", 32'(force_pc), 32'h0);
      cycle();
      clr_res();
    end
    stall = 1'b0;
    #1 chk("stall_issue", 32'(force_pc), 32'h1);
    chk("stall_data", 32'(force_pc_data), 32'h55);
    cycle();
    cycle();
    if_pc = 16'h0050;
    #1 chk("wrongpath_no_btb", 32'(pred_target), 32'h51);
    cycle();

    // Counter training on 0x10 (correctly predicted, so no redirects)
    if_pc = 16'h0010;
    set_res(1, 1, 'h10, 'h40, 'h40); cycle();
    set_res(1, 1, 'h10, 'h11, 'h11); cycle();
    set_res(1, 1, 'h10, 'h11, 'h11); cycle();
    clr_res();
    #1 chk("ctr1_not_taken", 32'(pred_taken), 32'h0);
    cycle();
    set_res(1, 1, 'h10, 'h11, 'h11); cycle();
    set_res(1, 1, 'h10, 'h11, 'h11); cycle();
    set_res(1, 1, 'h10, 'h40, 'h40); cycle();
    clr_res();
    #1 chk("ctr_no_underflow", 32'(pred_taken), 32'h0);
    cycle();

    // Aliasing replacement at same index
    set_res(1, 1, 'h10, 'h40, 'h40); cycle();
    set_res(1, 1, 'h20, 'h70, 'h70); cycle();
    clr_res();
    #1 chk("alias_miss", 32'(pred_target), 32'h11);
    cycle();
    if_pc = 16'h0020;
    #1 chk("alias_new", 32'(pred_target), 32'h70);
    cycle();

    // Counter saturation
    for (int i = 0; i < 18; i++) begin
      set_res(1, 0, 'h100 + i, 'h101 + i, 'h200 + i);
      cycle(); clr_res(); cycle(); cycle();
    end
    #1 chk("count_saturate", 32'(mispredict_count), 32'hF);
    cycle();

    // Reset while pending discards the redirect
    stall = 1'b1;
    set_res(1, 0, 'h60, 'h61, 'h88);
    cycle();
    clr_res();
    pulse_reset();
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("rst_no_issue", 32'(force_pc), 32'h0);
      cycle();
    end

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      if_pc = W'(pool[$urandom_range(0, 5)]);
      pc = pool[$urandom_range(0, 5)];
      an = ($urandom_range(0, 1) == 0) ? inc(pc) : tgts[$urandom_range(0, 3)];
      fn = ($urandom_range(0, 2) != 0) ? an : (($urandom_range(0, 1) == 0) ? inc(pc) : tgts[$urandom_range(0, 3)]);
      set_res($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, pc, fn, an);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Parametrised control-hazard unit for the pipelined CPU. It predicts the next fetch PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It checks each resolved control-flow instruction against the path actually fetched and issues a registered PC redirect plus per-stage flush pulses on a mispredict. It sits between the fetch stage (prediction) and the resolution stage (redirect/update), replacing the purely combinational PC-compare hazard check.

## Interface
- WORD_SIZE, 16, PC/data width; PCs are word addresses, sequential next PC = pc+1
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX_W = log2(BTB_ENTRIES)
- FLUSH_STAGES, 2, number of front-end stage registers to squash on redirect
- CNT_WIDTH, 16, width of mispredict counter

Ports (clock and reset first; single clock, reset asynchronous active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- if_pc  in  WORD_SIZE  PC being fetched this cycle
- pred_target  out  WORD_SIZE  predicted next fetch PC (combinational from if_pc and BTB)
- pred_taken  out  1  BTB hit with counter ≥ 2
- res_valid  in  1  resolution-stage instruction is valid
- res_is_branch  in  1  resolved instruction is a branch/jump
- res_pc  in  WORD_SIZE  PC of resolved instruction
- res_fetched_next  in  WORD_SIZE  PC actually fetched after it (the prediction used)
- res_actual_next  in  WORD_SIZE  architecturally correct next PC
- stall  in  1  pipeline stall; freezes redirect issue
- force_pc  out  1  redirect fetch to force_pc_data this cycle
- force_pc_data  out  WORD_SIZE  redirect target
- flush  out  FLUSH_STAGES  per-stage squash, bit 0 = youngest (IF/ID)
- mispredict_count  out  CNT_WIDTH  saturating count of redirects issued

## Operation
- BTB entry: valid, tag = pc[WORD_SIZE-1:IDX_W], target, ctr[1:0]; index = pc[IDX_W-1:0].
- Lookup: hit = valid & tag match. pred_taken = hit & ctr[1]; pred_target = pred_taken ? target : if_pc+1 (mod 2^WORD_SIZE).
- Accept condition: res_valid & !pending. While pending, resolution inputs are wrong-path and ignored (no BTB update, no count).
- Mispredict: accepted & (res_fetched_next != res_actual_next). This applies to any instruction, branch or not. Latch res_actual_next into redirect register, set pending.
- BTB update, on accepted & res_is_branch; taken = (res_actual_next != res_pc+1):
  - taken & hit: target ← res_actual_next, ctr saturating increment (max 3).
  - taken & miss: allocate/replace: valid=1, tag, target, ctr=2.
  - not taken & hit: ctr saturating decrement (min 0); target unchanged.
  - not taken & miss: no change.
- FSM: IDLE → (mispredict) PENDING. PENDING & stall → PENDING (hold). PENDING & !stall → ISSUE for one cycle → IDLE. A new accept in the ISSUE cycle is ignored (wrong path).
- mispredict_count increments once per ISSUE cycle, saturating at all-ones.

## Timing
- Reset values: force_pc=0, force_pc_data=0, flush=0, mispredict_count=0, FSM=IDLE, all BTB valid=0, ctr=1, tag/target=0.
- Prediction: zero latency (combinational read of registered BTB); an update written at edge N is visible to lookups after edge N.
- Redirect latency: mispredict accepted in cycle N, no stall → force_pc=1 and flush=all-ones in cycle N+1, exactly one cycle.
- Stall: if stall is high in cycle N+1 or later, force_pc/flush stay 0. They issue in the first cycle with stall low.
- force_pc_data is held stable from the latch edge through the ISSUE cycle.
- Same-index read/update in the same cycle: lookup returns pre-update contents.
- Reset asserted mid-PENDING: redirect discarded, outputs 0 asynchronously.

## Structure
- Shared package/header (with existing opcodes definitions): WORD_SIZE default, FSM state encodings (IDLE, PENDING, ISSUE), counter constants (CTR_INIT=1, CTR_ALLOC=2, CTR_MAX=3).
- One sub-module: btb_table (storage, combinational lookup, single write port with counter update logic). Redirect FSM, flush generation and counter live in the top level.

## Test plan
- Reset then if_pc=0x0010 → pred_taken=0, pred_target=0x0011; all outputs 0, mispredict_count=0.
- Resolve branch res_pc=0x0010, fetched_next=0x0011, actual_next=0x0040 → next cycle force_pc=1, force_pc_data=0x0040, flush=2'b11 for one cycle, count=1. Then if_pc=0x0010 → pred_taken=1, pred_target=0x0040.
- Mispredict with stall held 3 cycles → force_pc stays 0 for 3 cycles, issues in the 4th with data unchanged. A res_valid mispredict during pending produces no second redirect and no BTB change.
- Train 0x0010 taken twice (ctr 3), then not-taken twice → ctr 1, pred_taken=0. A further not-taken keeps ctr 0 with no underflow.
- Aliasing: train 0x0010, then taken branch at 0x0020 (same index, BTB_ENTRIES=16) → entry replaced. Lookup of 0x0010 now misses, giving pred_target 0x0011.
- Force mispredict_count to saturation (CNT_WIDTH=4, 16 mispredicts) → stays 0xF. Assert reset mid-PENDING → force_pc never issues, count=0.
